// File: rtl/int_req_arb.sv
// Interrupt requester/arbiter: synchronises up to four device request lines, latches
// rising edges as pending flags and presents the best eligible request until acked.
module int_req_arb #(
  parameter int         NUM_SRC      = 4,
  parameter logic [7:0] RST_VEC_BASE = 8'h80
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] src_req,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_sel,
  input  logic [15:0]        bus,
  input  logic               int_ack,
  output logic [2:0]         int_priority,
  output logic [7:0]         int_vec,
  output logic               int_valid,
  output logic [NUM_SRC-1:0] pend
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARB     = 2'd1,
    PRESENT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
  logic [NUM_SRC-1:0] arm_q, arm_d, pend_q, pend_d;
  logic [1:0]         vld_q, vld_d;
  logic [2:0]         prio_q [NUM_SRC];
  logic [2:0]         prio_d [NUM_SRC];
  logic [7:0]         vec_q  [NUM_SRC];
  logic [7:0]         vec_d  [NUM_SRC];
  logic [1:0]         win_idx_q, win_idx_d;
  logic [2:0]         int_priority_q, int_priority_d;
  logic [7:0]         int_vec_q, int_vec_d;
  logic               int_valid_q, int_valid_d;
  logic [NUM_SRC-1:0] rise_s, elig_s, clr_s;
  logic               any_elig_s, beats_s;
  logic [1:0]         best_idx_s;
  logic [2:0]         best_prio_s;

  // A line only arms once a genuine low has been seen after reset, so lines
  // held high through reset cannot raise a request until they toggle.
  always_comb begin
    sync1_d = src_req;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
    vld_d   = {vld_q[0], 1'b1};
    arm_d   = arm_q | (~sync2_q & {NUM_SRC{vld_q[1]}});
    rise_s  = sync2_q & ~sync3_q & arm_q;
    prio_d  = prio_q;
    vec_d   = vec_q;
    if (cfg_we) begin
      prio_d[cfg_sel] = bus[10:8];
      vec_d[cfg_sel]  = bus[7:0];
    end else begin
      prio_d = prio_q;
      vec_d  = vec_q;
    end
  end

  // Highest priority wins; strict compare keeps the lowest index on ties.
  always_comb begin
    elig_s      = '0;
    any_elig_s  = 1'b0;
    best_idx_s  = 2'd0;
    best_prio_s = 3'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      elig_s[i] = pend_q[i] && (prio_q[i] != 3'd0);
      if (elig_s[i] && (!any_elig_s || (prio_q[i] > best_prio_s))) begin
        any_elig_s  = 1'b1;
        best_idx_s  = 2'(i);
        best_prio_s = prio_q[i];
      end else begin
        any_elig_s  = any_elig_s;
        best_idx_s  = best_idx_s;
        best_prio_s = best_prio_s;
      end
    end
    beats_s = any_elig_s && ((best_prio_s > int_priority_q) ||
              ((best_prio_s == int_priority_q) && (best_idx_s < win_idx_q)));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = any_elig_s ? ARB : IDLE;
      ARB:     state_d = any_elig_s ? PRESENT : IDLE;
      PRESENT: begin
        if (int_ack) begin
          state_d = IDLE;
        end else if (beats_s || (cfg_we && (cfg_sel == win_idx_q))) begin
          state_d = ARB;
        end else begin
          state_d = PRESENT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Presented outputs only change when leaving ARB or on an acknowledge.
  always_comb begin
    win_idx_d      = win_idx_q;
    int_priority_d = int_priority_q;
    int_vec_d      = int_vec_q;
    int_valid_d    = int_valid_q;
    clr_s          = '0;
    case (state_q)
      IDLE: begin
        int_priority_d = 3'd0;
        int_vec_d      = 8'd0;
        int_valid_d    = 1'b0;
      end
      ARB: begin
        if (any_elig_s) begin
          win_idx_d      = best_idx_s;
          int_priority_d = best_prio_s;
          int_vec_d      = vec_q[best_idx_s];
          int_valid_d    = 1'b1;
        end else begin
          int_priority_d = 3'd0;
          int_vec_d      = 8'd0;
          int_valid_d    = 1'b0;
        end
      end
      PRESENT: begin
        if (int_ack) begin
          clr_s          = {{(NUM_SRC-1){1'b0}}, 1'b1} << win_idx_q;
          int_priority_d = 3'd0;
          int_vec_d      = 8'd0;
          int_valid_d    = 1'b0;
        end else begin
          int_priority_d = int_priority_q;
          int_vec_d      = int_vec_q;
          int_valid_d    = int_valid_q;
        end
      end
      default: begin
        int_priority_d = 3'd0;
        int_vec_d      = 8'd0;
        int_valid_d    = 1'b0;
      end
    endcase
    pend_d = (pend_q & ~clr_s) | rise_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      sync1_q        <= '0;
      sync2_q        <= '0;
      sync3_q        <= '0;
      arm_q          <= '0;
      vld_q          <= 2'b00;
      pend_q         <= '0;
      win_idx_q      <= 2'd0;
      int_priority_q <= 3'd0;
      int_vec_q      <= 8'd0;
      int_valid_q    <= 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
        prio_q[i] <= 3'd0;
        vec_q[i]  <= RST_VEC_BASE + 8'(i);
      end
    end else begin
      state_q        <= state_d;
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      sync3_q        <= sync3_d;
      arm_q          <= arm_d;
      vld_q          <= vld_d;
      pend_q         <= pend_d;
      win_idx_q      <= win_idx_d;
      int_priority_q <= int_priority_d;
      int_vec_q      <= int_vec_d;
      int_valid_q    <= int_valid_d;
      prio_q         <= prio_d;
      vec_q          <= vec_d;
    end
  end

  assign int_priority = int_priority_q;
  assign int_vec      = int_vec_q;
  assign int_valid    = int_valid_q;
  assign pend         = pend_q;

endmodule

// File: tb/tb_int_req_arb.sv
// Bench for int_req_arb: directed scenarios plus random traffic, checked every cycle
// against a behavioural model of the request/arbitration rules.
module tb_int_req_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  src_req;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [15:0] bus;
  logic        int_ack;
  logic [2:0]  int_priority;
  logic [7:0]  int_vec;
  logic        int_valid;
  logic [3:0]  pend;

  int errors = 0;
  int checks = 0;

  // Model state: config table, pending set, rise history and what is shown to the CPU.
  int         m_prio [4];
  int         m_vec  [4];
  logic [3:0] m_pend, m_prev, m_dly0, m_dly1;
  bit         m_have_prev;
  int         m_phase;    // 0 nothing shown, 1 arbitrating, 2 showing a request
  int         m_idx, m_oprio, m_ovec;
  bit         m_oval;

  always #5 clk = ~clk;

  int_req_arb dut (
    .clk(clk), .rst_n(rst_n), .src_req(src_req), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .bus(bus), .int_ack(int_ack), .int_priority(int_priority), .int_vec(int_vec),
    .int_valid(int_valid), .pend(pend)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = 4'b0; m_prev = 4'b0; m_dly0 = 4'b0; m_dly1 = 4'b0;
    m_have_prev = 1'b0; m_phase = 0; m_idx = 0;
    m_oprio = 0; m_ovec = 0; m_oval = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_prio[i] = 0;
      m_vec[i]  = 128 + i;
    end
  endtask

  // Best eligible source, or -1 when none is eligible.
  function automatic int pick();
    int b = -1;
    for (int i = 0; i < 4; i++)
      if (m_pend[i] && m_prio[i] != 0 && (b < 0 || m_prio[i] > m_prio[b])) b = i;
    return b;
  endfunction

  task automatic show_none();
    m_oval = 1'b0; m_oprio = 0; m_ovec = 0;
  endtask

  // One clock edge of the model, using the inputs in effect at that edge.
  task automatic model_step();
    int w;
    logic [3:0] clr, setv;
    w    = pick();
    clr  = 4'b0;
    setv = m_dly1;
    m_dly1 = m_dly0;
    m_dly0 = m_have_prev ? (src_req & ~m_prev) : 4'b0;
    m_prev = src_req;
    m_have_prev = 1'b1;
    if (m_phase == 0) begin
      if (w >= 0) m_phase = 1;
    end else if (m_phase == 1) begin
      if (w >= 0) begin
        m_phase = 2; m_idx = w; m_oprio = m_prio[w]; m_ovec = m_vec[w]; m_oval = 1'b1;
      end else begin
        m_phase = 0; show_none();
      end
    end else begin
      if (int_ack) begin
        clr[m_idx] = 1'b1; show_none(); m_phase = 0;
      end else if (w >= 0 && (m_prio[w] > m_oprio || (m_prio[w] == m_oprio && w < m_idx))) begin
        m_phase = 1;
      end else if (cfg_we && int'(cfg_sel) == m_idx) begin
        m_phase = 1;
      end
    end
    m_pend = (m_pend & ~clr) | setv;
    if (cfg_we) begin
      m_prio[cfg_sel] = int'(bus[10:8]);
      m_vec[cfg_sel]  = int'(bus[7:0]);
    end
  endtask

  task automatic compare_outputs();
    chk("pend", int'(pend), int'(m_pend));
    chk("int_valid", int'(int_valid), int'(m_oval));
    chk("int_priority", int'(int_priority), m_oprio);
    chk("int_vec", int'(int_vec), m_ovec);
  endtask

  // Inputs set by the caller are sampled at the next posedge; outputs compared at negedge.
  task automatic cycle(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_outputs();
      cfg_we  = 1'b0;
      int_ack = 1'b0;
    end
  endtask

  task automatic cfg(input logic [1:0] sel, input logic [15:0] data);
    cfg_we = 1'b1; cfg_sel = sel; bus = data;
    cycle();
  endtask

  task automatic ack();
    int_ack = 1'b1;
    cycle();
  endtask

  initial begin
    logic [3:0] one;
    one = 4'b0001;
    rst_n = 1'b0; src_req = 4'b0; cfg_we = 1'b0; cfg_sel = 2'd0; bus = 16'h0; int_ack = 1'b0;
    model_reset();
    #22;
    chk("reset pend", int'(pend), 0);
    chk("reset int_valid", int'(int_valid), 0);
    chk("reset int_vec", int'(int_vec), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(4);

    // Single source: timing of pend and presentation, then ack.
    cfg(2'd1, 16'h0481);
    src_req = 4'b0010;
    cycle(3);
    chk("t1 pend after 3 edges", int'(pend), 4'b0010);
    cycle(2);
    chk("t1 valid", int'(int_valid), 1);
    chk("t1 prio", int'(int_priority), 4);
    chk("t1 vec", int'(int_vec), 8'h81);
    ack();
    chk("t1 pend cleared", int'(pend), 0);
    chk("t1 valid cleared", int'(int_valid), 0);
    src_req = 4'b0;
    cycle(2);

    // Two simultaneous requests with different priorities.
    cfg(2'd0, 16'h0280);
    cfg(2'd2, 16'h0690);
    src_req = 4'b0101;
    cycle(5);
    chk("t2 first prio", int'(int_priority), 6);
    chk("t2 first vec", int'(int_vec), 8'h90);
    ack();
    cycle(2);
    chk("t2 second prio", int'(int_priority), 2);
    chk("t2 second vec", int'(int_vec), 8'h80);
    ack();
    cycle(3);
    chk("t2 idle", int'(int_valid), 0);
    src_req = 4'b0;
    cycle(2);

    // Preemption of a low-priority presentation.
    cfg(2'd3, 16'h01A3);
    cfg(2'd0, 16'h0780);
    src_req = 4'b1000;
    cycle(5);
    chk("t3 low vec", int'(int_vec), 8'hA3);
    src_req = 4'b1001;
    cycle(4);
    chk("t3 arb holds prio", int'(int_priority), 1);
    chk("t3 arb holds vec", int'(int_vec), 8'hA3);
    cycle();
    chk("t3 preempt prio", int'(int_priority), 7);
    chk("t3 preempt vec", int'(int_vec), 8'h80);
    ack();
    chk("t3 only pend0 cleared", int'(pend), 4'b1000);
    cycle(2);
    chk("t3 re-present vec", int'(int_vec), 8'hA3);
    ack();
    src_req = 4'b0;
    cycle(2);

    // Equal priorities and a disabled source.
    cfg(2'd1, 16'h0511);
    cfg(2'd2, 16'h0522);
    cfg(2'd3, 16'h0033);
    src_req = 4'b1110;
    cycle(5);
    chk("t4 tie lowest idx", int'(int_vec), 8'h11);
    ack();
    cycle(2);
    chk("t4 tie second", int'(int_vec), 8'h22);
    ack();
    cycle(3);
    chk("t4 prio0 pending", int'(pend), 4'b1000);
    chk("t4 prio0 not shown", int'(int_valid), 0);
    src_req = 4'b0;
    cycle(2);

    // Ack coinciding with a new edge on the winner, then ack while idle.
    src_req = 4'b0010;
    cycle(5);
    src_req = 4'b0;
    cycle(2);
    src_req = 4'b0010;
    cycle(2);
    ack();
    chk("t5 set beats clear", int'(pend), 4'b1010);
    cycle(2);
    chk("t5 re-presented", int'(int_vec), 8'h11);
    ack();
    cycle();
    ack();
    chk("t5 idle ack ignored", int'(pend), 4'b1000);
    src_req = 4'b0;
    cycle(2);

    // Asynchronous reset during a presentation with lines held high.
    src_req = 4'b0100;
    cycle(5);
    src_req = 4'b1111;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6 async valid", int'(int_valid), 0);
    chk("t6 async prio", int'(int_priority), 0);
    chk("t6 async pend", int'(pend), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(8);
    chk("t6 held high ignored", int'(pend), 0);
    src_req = 4'b0;
    cycle(2);
    src_req = 4'b0001;
    cycle(3);
    chk("t6 toggle requests", int'(pend), 4'b0001);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(7, 0) == 0) src_req = src_req ^ (one << $urandom_range(3, 0));
      if ($urandom_range(15, 0) == 0) begin
        cfg_we = 1'b1; cfg_sel = 2'($urandom_range(3, 0)); bus = 16'($urandom);
      end
      if ((m_oval && $urandom_range(3, 0) == 0) || $urandom_range(31, 0) == 0) int_ack = 1'b1;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/int_req_arb.md
Name: int_req_arb

Overview:
- Device-side interrupt requester and arbiter. It collects interrupt requests from up to four peripherals (keyboard, display, timer, spare).
- It presents the single highest-priority pending request as int_priority/int_vec to the CPU interrupt controller, which compares that priority against the current PSR priority.
- It holds the presented request stable until the CPU acknowledges it, then clears that source's pending flag.
- Per-source priority and vector are programmed through a register-write port fed from the system bus.

Parameters:
- NUM_SRC, 4, number of request sources. Fixed at 4; index width is 2.
- RST_VEC_BASE, 8'h80, reset vector of source i is RST_VEC_BASE+i.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- src_req  input  4  level requests from devices, asynchronous to clk
- cfg_we  input  1  config write strobe, single cycle
- cfg_sel  input  2  source index being configured
- bus  input  16  write data: bus[10:8]=priority, bus[7:0]=vector
- int_ack  input  1  single-cycle pulse from CPU when it loads the interrupt vector
- int_priority  output  3  priority of the presented request; 0 = none
- int_vec  output  8  vector of the presented request
- int_valid  output  1  a request is currently presented
- pend  output  4  pending flags, for status readback

Behaviour:
- Reset (async): pend=0, state=IDLE, int_priority=0, int_vec=0, int_valid=0. Synchronizers cleared. prio[i]=0 (all sources disabled), vec[i]=RST_VEC_BASE+i.
- Reset asserted mid-operation aborts any presentation immediately. No request survives reset.
- Input capture:
  - src_req passes through a 2-flop synchronizer, then a rising-edge detector.
  - pend[i] is set 3 clk edges after src_req[i] is first sampled high.
  - A level held high sets pend only once; it must fall and rise again to re-request.
- Config:
  - On cfg_we, prio[cfg_sel]<=bus[10:8] and vec[cfg_sel]<=bus[7:0], visible the next cycle.
  - Priority 0 means disabled. A pending source with prio 0 stays pending but is never eligible.
- Eligibility: elig[i] = pend[i] && prio[i]!=0.
- Winner: elig source with the highest prio. Ties go to the lowest index.
- FSM IDLE:
  - int_valid=0, int_priority=0, int_vec=0.
  - If any elig -> ARB.
- FSM ARB (one cycle):
  - Register win_idx.
  - Load int_priority=prio[win], int_vec=vec[win], int_valid=1.
  - -> PRESENT.
  - Outputs are valid 2 edges after the pend set edge.
- FSM PRESENT (outputs held stable):
  - int_ack:
    - pend[win_idx] cleared.
    - Outputs zeroed, int_valid=0.
    - -> IDLE. If other elig sources remain, IDLE -> ARB on the next edge.
  - else, an elig source now beats the presented priority (strictly higher prio, or equal prio with lower index):
    - -> ARB (preemption).
    - Outputs stay at their old values during the ARB cycle, then update.
  - else, cfg_we targets win_idx:
    - -> ARB to re-read the new values.
    - If the new prio is 0 and nothing else is elig, ARB instead goes to IDLE with outputs zeroed.
- int_ack outside PRESENT is ignored.
- Simultaneous events:
  - Edge-set and ack-clear on the same source in the same cycle: set wins, pend stays 1, and the source is re-arbitrated.
  - Edge on one source while another is acked: both actions take effect.
- Every output is a flop output; there is no combinational path from inputs to outputs.
- Priority is compared unsigned, 3 bits. There is no arithmetic wrap.

Test Plan:
- Reset, then write cfg src1 bus=16'h0481 and pulse src_req[1] -> pend=4'b0010 after 3 edges; 2 edges later int_valid=1, int_priority=3'd4, int_vec=8'h81; int_ack -> pend=0, int_valid=0, int_priority=0 next edge.
- src0 prio 2 vec 8'h80 and src2 prio 6 vec 8'h90, requests rising in the same cycle -> presents 6/8'h90; after ack, presents 2/8'h80 within 2 edges; after second ack, IDLE.
- Preemption: src3 prio 1 presented; src0 prio 7 request -> one ARB cycle with old outputs 1/vec3, then 7/vec0. Ack clears only pend[0]; src3 is re-presented afterwards.
- Equal priority 5 on src1 and src2 -> src1 presented first, src2 after src1 is acked. Source with prio 0 requesting -> pend bit set, int_valid stays 0.
- int_ack asserted in the same cycle as a new src_req edge on the winner -> pend stays 1, request re-presented; int_ack while IDLE -> no state change.
- rst_n dropped while in PRESENT -> all outputs 0 asynchronously. After release, held-high src_req lines generate no request until they toggle.
